// File: rtl/product_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : product_dispatcher
// Description : In-order request queue that routes each head entry to the
//               consumer port selected by its kind tag. Disabled kinds are
//               absorbed and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module product_dispatcher #(
    parameter int DATA_W = 32,
    parameter int KIND_W = 2,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [KIND_W-1:0]         in_kind,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [(2**KIND_W)-1:0]    kind_en,
    output logic [(2**KIND_W)-1:0]    out_valid,
    input  logic [(2**KIND_W)-1:0]    out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = KIND_W + DATA_W;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [KIND_W-1:0] head_kind_q, head_kind_d;

    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic [ENT_W-1:0]  next_head;

    always_comb begin
        in_ready   = rst_n && (level_q != LVL_W'(DEPTH));
        accept     = in_valid && in_ready;
        push       = accept && kind_en[in_kind];
        drop       = accept && !kind_en[in_kind];
        pop        = (level_q != '0) && out_ready[head_kind_q];

        out_valid  = '0;
        if (level_q != '0) begin
            out_valid[head_kind_q] = 1'b1;
        end

        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        // The next head is the entry being written this cycle only when the
        // queue is (or becomes) a single-entry queue; otherwise it is in storage.
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            next_head = {in_kind, in_data};
        end else begin
            next_head = mem_q[rd_ptr_d];
        end

        out_data_d  = out_data_q;
        head_kind_d = head_kind_q;
        if (level_d != '0) begin
            out_data_d  = next_head[DATA_W-1:0];
            head_kind_d = next_head[ENT_W-1 -: KIND_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_cnt_q  <= '0;
            out_data_q  <= '0;
            head_kind_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_cnt_q  <= drop_cnt_d;
            out_data_q  <= out_data_d;
            head_kind_q <= head_kind_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_kind, in_data};
        end
    end

    assign out_data = out_data_q;
    assign level    = level_q;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_product_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_dispatcher
// Description : Scoreboard bench for product_dispatcher; a second instance
//               with a 2-bit drop counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_dispatcher;

    localparam int DATA_W = 32;
    localparam int KIND_W = 2;
    localparam int DEPTH  = 8;
    localparam int NK     = 4;
    localparam int ENT_W  = KIND_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [KIND_W-1:0] in_kind;
    logic [DATA_W-1:0] in_data;
    logic [NK-1:0]     kind_en;
    logic [NK-1:0]     out_ready;

    logic              in_ready;
    logic [NK-1:0]     out_valid;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        level;
    logic [15:0]       drop_cnt;

    logic              s_in_ready;
    logic [NK-1:0]     s_out_valid;
    logic [DATA_W-1:0] s_out_data;
    logic [3:0]        s_level;
    logic [1:0]        s_drop_cnt;

    always #5 clk = ~clk;

    product_dispatcher #(.DATA_W(DATA_W), .KIND_W(KIND_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_data(in_data), .kind_en(kind_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .drop_cnt(drop_cnt)
    );

    product_dispatcher #(.DATA_W(DATA_W), .KIND_W(KIND_W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_kind(in_kind), .in_data(in_data), .kind_en(kind_en),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .level(s_level), .drop_cnt(s_drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [ENT_W-1:0]  sb[$];
    int                m_drops;
    int                m_drops_sat;
    logic [DATA_W-1:0] m_last;
    bit                last_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs to the model, then advance the model
    // with whatever handshakes the model says happen at the next edge.
    task automatic step();
        logic [ENT_W-1:0]  ent;
        logic [KIND_W-1:0] hk;
        logic [NK-1:0]     ev;
        bit                exp_ready;
        bit                acc;
        bit                pop;
        @(negedge clk);
        exp_ready = (sb.size() != DEPTH);
        ev  = '0;
        pop = 1'b0;
        if (sb.size() > 0) begin
            ent    = sb[0];
            hk     = ent[ENT_W-1 -: KIND_W];
            m_last = ent[DATA_W-1:0];
            ev[hk] = 1'b1;
            pop    = out_ready[hk];
        end
        check_eq("in_ready", in_ready, exp_ready);
        check_eq("level", level, sb.size());
        check_eq("out_valid", out_valid, ev);
        check_eq("out_data", out_data, m_last);
        check_eq("drop_cnt", drop_cnt, m_drops);
        check_eq("sat_in_ready", s_in_ready, exp_ready);
        check_eq("sat_level", s_level, sb.size());
        check_eq("sat_out_valid", s_out_valid, ev);
        check_eq("sat_out_data", s_out_data, m_last);
        check_eq("sat_drop_cnt", s_drop_cnt, m_drops_sat);
        acc = in_valid && exp_ready;
        @(posedge clk);
        if (pop) void'(sb.pop_front());
        if (acc) begin
            if (kind_en[in_kind]) begin
                sb.push_back({in_kind, in_data});
            end else begin
                if (m_drops < 65535) m_drops++;
                if (m_drops_sat < 3) m_drops_sat++;
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic do_reset(input int n);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_eq("in_ready_rst", in_ready, 0);
            @(posedge clk);
            #1;
        end
        sb.delete();
        m_drops     = 0;
        m_drops_sat = 0;
        m_last      = '0;
        rst_n       = 1'b1;
    endtask

    task automatic send(input logic [KIND_W-1:0] k, input logic [DATA_W-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_kind  = k;
        in_data  = d;
        do begin
            step();
            n++;
        end while (!last_acc && n < 30);
        if (!last_acc) check_eq("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_kind   = '0;
        in_data   = '0;
        kind_en   = 4'b1111;
        out_ready = 4'b1111;
        @(posedge clk);
        #1;
        do_reset(3);
        idle(2);

        // Ordering and routing across all four kinds
        for (int i = 0; i < 4; i++) send(KIND_W'(i), 32'hA0 + i);
        idle(6);

        // Fill to the brim; ninth request waits, then a pop frees one slot
        out_ready = 4'b0000;
        for (int i = 0; i < 8; i++) send(KIND_W'(i % 4), 32'hB0 + i);
        in_valid = 1'b1;
        in_kind  = 2'd0;
        in_data  = 32'hB8;
        step();
        out_ready = 4'b0001;
        step();
        step();
        out_ready = 4'b1111;
        idle(12);

        // Drops on a disabled kind, enough to saturate the 2-bit counter
        kind_en = 4'b1011;
        for (int i = 0; i < 3; i++) send(2'd2, 32'hD0 + i);
        idle(2);
        for (int i = 0; i < 2; i++) send(2'd2, 32'hD8 + i);
        idle(2);
        kind_en = 4'b1111;

        // Reset while entries are pending and consumers are ready
        out_ready = 4'b0000;
        for (int i = 0; i < 5; i++) send(KIND_W'(i % 4), 32'hC0 + i);
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        do_reset(1);
        idle(2);

        // Head-of-line blocking
        out_ready = 4'b0001;
        send(2'd1, 32'h11);
        send(2'd0, 32'h10);
        idle(3);
        out_ready = 4'b0011;
        idle(3);

        // Disabling a kind does not affect an entry already queued
        out_ready = 4'b0000;
        send(2'd3, 32'hF3);
        in_valid  = 1'b0;
        kind_en   = 4'b0111;
        out_ready = 4'b1111;
        idle(3);
        kind_en   = 4'b1111;

        // Continuous push and pop at level 3 across pointer wrap
        out_ready = 4'b0000;
        for (int i = 0; i < 3; i++) send(KIND_W'(i), 32'hE0 + i);
        out_ready = 4'b1111;
        for (int i = 3; i < 23; i++) send(KIND_W'(i % 4), 32'hE0 + i);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/product_dispatcher.md
Name: product_dispatcher

Overview:
- Buffered request dispatcher that sits directly downstream of the product-creation stage.
- Accepts tagged product requests (kind id + payload), queues them in order, and delivers each to the one consumer port selected by its kind.
- Requests whose kind is currently disabled are absorbed, dropped and counted.
- Used as the DUT consumer for factory-generated transactions in the pattern examples.

Parameters:
DATA_W, 32, payload width in bits
KIND_W, 2, kind tag width; number of consumer ports N_KINDS = 2**KIND_W
DEPTH, 8, queue entries; power of two, >= 2
CNT_W, 16, width of the drop counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream request valid
in_ready  out  1  upstream ready; high when queue not full
in_kind  in  KIND_W  request kind tag
in_data  in  DATA_W  request payload
kind_en  in  N_KINDS  per-kind enable mask, sampled at accept time
out_valid  out  N_KINDS  one-hot (or zero) consumer valid
out_ready  in  N_KINDS  per-consumer ready
out_data  out  DATA_W  payload of queue head, shared by all consumers
level  out  $clog2(DEPTH)+1  current queue occupancy
drop_cnt  out  CNT_W  number of dropped requests, saturating

Behaviour:
- Reset: synchronous, active-low; applied on any clk edge with rst_n=0, including mid-transfer.
  - Flushes the queue: rd/wr pointers 0, level=0.
  - drop_cnt=0, out_valid=0, out_data=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
  - No transfer is recorded on a reset cycle.
- Accept: occurs when in_valid && in_ready.
  - If kind_en[in_kind]=1: entry {in_kind,in_data} is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - If kind_en[in_kind]=0: the request is consumed (handshake completes) and is not stored; drop_cnt increments, saturating at 2**CNT_W-1.
- in_ready = (level != DEPTH). No bypass: a full queue refuses input even if a pop occurs in the same cycle.
- Dispatch:
  - When level != 0: out_valid[head_kind]=1, all other bits 0, out_data = head payload.
  - When level == 0: out_valid=0 and out_data holds its last value.
  - Pop occurs when out_valid[k] && out_ready[k]; rd_ptr increments modulo DEPTH.
  - out_ready bits of non-selected kinds are ignored.
- Latency: an entry written into an empty queue appears on out_valid the next cycle (1-cycle latency, registered storage, no combinational in->out path).
- Ordering: strict FIFO across all kinds. A stalled head blocks all later entries (head-of-line blocking is intended).
- Stability: while out_valid is high and unacknowledged, out_valid and out_data must not change.
- Simultaneous push and pop: both take effect and level is unchanged. Valid when 0 < level < DEPTH, and when level == 0 with a push only.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked explicitly (no pointer-compare ambiguity).
- kind_en changes affect only future accepts; entries already queued are always dispatched.
- Protocol assumption: upstream holds in_valid/in_kind/in_data stable until accepted. Violations are outside the contract.

Test Plan:
- Reset mid-operation: fill 5 entries, assert rst_n=0 for 1 cycle while out_ready=1 -> next cycle level=0, out_valid=0, drop_cnt=0; in_ready=1 after release.
- Ordering/routing, DEPTH=8: push kinds 0,1,2,3 with data 0xA0..0xA3, all out_ready=1 -> out_valid sequence 0001,0010,0100,1000 with matching data; first valid 1 cycle after the first accept.
- Full boundary: out_ready=0, push 9 requests -> 8 accepted, level=8, in_ready=0 on the 9th. Then out_ready=1 for the head kind with in_valid held -> pop occurs and in_ready rises the following cycle (no same-cycle bypass).
- Drop path: kind_en=4'b1011, push kind 2 three times -> drop_cnt=3, level=0, out_valid never set. Force CNT_W=2, push 5 drops -> drop_cnt saturates at 3.
- Head-of-line blocking: queue kinds 1,0 with out_ready=4'b0001 -> nothing pops. Set out_ready[1]=1 -> kind 1 pops, then kind 0 pops the next cycle.
- Wrap and concurrency: stream 20 entries with continuous push and pop at level 3 -> level stays 3 and payloads emerge in order across pointer wrap.
